// File: rtl/multiplier_fpn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : multiplier_fpn                                             |
// | Description : Parametrised IEEE-754 binary floating-point multiplier.    |
// |               Multi-cycle FSM (one operation in flight), round to        |
// |               nearest even, subnormals flushed to zero, exception flags. |
// |               Optional flag logic guarded by MULTIPLIER_FPN_FLAGS_EN;    |
// |               without it `flags` is tied to zero.                        |
// | Ports       : clk    - clock, rising edge                                |
// |               reset  - asynchronous active-low reset                     |
// |               rd     - start request, x/y sampled in IDLE                |
// |               x, y   - operands, W = 1+EXP_W+MAN_W bits                  |
// |               z      - result, held until the next result                |
// |               wr     - one-cycle result-valid pulse                      |
// |               busy   - high in every state except IDLE                   |
// |               flags  - {invalid, overflow, underflow, inexact}           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multiplier_fpn #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd,
  input  logic [EXP_W+MAN_W:0] x,
  input  logic [EXP_W+MAN_W:0] y,
  output logic [EXP_W+MAN_W:0] z,
  output logic                 wr,
  output logic                 busy,
  output logic [3:0]           flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  // Exponent arithmetic carries two extra bits: one for the sum range, one sign.
  localparam int EW = EXP_W + 2;

  localparam logic [EW-1:0] C_BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] C_EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]  C_QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [W-2:0]  C_INF_MAG = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPECIAL = 3'd1,
    S_MULT    = 3'd2,
    S_ROUND   = 3'd3,
    S_PUT_Z   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [W-1:0]     r_x;
  logic [W-1:0]     r_y;
  logic [MAN_W:0]   r_mant;
  logic             r_guard;
  logic             r_sticky;
  logic [EW-1:0]    r_exp;
  logic [W-1:0]     r_res;

  // ---------------------------------------------------------------- decode
  logic             w_sx, w_sy, w_sign;
  logic [EXP_W-1:0] w_ex, w_ey;
  logic [MAN_W-1:0] w_fx, w_fy;
  logic             w_x_nan, w_y_nan, w_x_inf, w_y_inf;
  logic             w_x_exp0, w_y_exp0, w_x_zero, w_y_zero;
  logic             w_any_nan, w_inf_zero, w_special;

  assign {w_sx, w_ex, w_fx} = r_x;
  assign {w_sy, w_ey, w_fy} = r_y;
  assign w_sign     = w_sx ^ w_sy;
  assign w_x_nan    = (&w_ex) & (|w_fx);
  assign w_y_nan    = (&w_ey) & (|w_fy);
  assign w_x_inf    = (&w_ex) & ~(|w_fx);
  assign w_y_inf    = (&w_ey) & ~(|w_fy);
  assign w_x_exp0   = ~(|w_ex);
  assign w_y_exp0   = ~(|w_ey);
  assign w_x_zero   = w_x_exp0 & ~(|w_fx);
  assign w_y_zero   = w_y_exp0 & ~(|w_fy);
  assign w_any_nan  = w_x_nan | w_y_nan;
  assign w_inf_zero = (w_x_inf & w_y_zero) | (w_y_inf & w_x_zero);
  // Anything with an all-ones or all-zeros exponent resolves without MULT.
  assign w_special  = w_x_nan | w_y_nan | w_x_inf | w_y_inf | w_x_exp0 | w_y_exp0;

  logic [W-1:0] w_spec_res;

  always_comb begin
    w_spec_res = {w_sign, {(W-1){1'b0}}};
    if (w_any_nan || w_inf_zero) begin
      w_spec_res = C_QNAN;
    end else if (w_x_inf || w_y_inf) begin
      w_spec_res = {w_sign, C_INF_MAG};
    end
  end

  // ---------------------------------------------------------------- multiply
  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_norm;
  logic [EW-1:0] w_exp_sum;

  assign w_prod    = PW'({1'b1, w_fx}) * PW'({1'b1, w_fy});
  // Product lies in [1,4): normalise so the leading one sits at the MSB.
  assign w_norm    = w_prod[PW-1] ? w_prod : {w_prod[PW-2:0], 1'b0};
  // Two's complement wrap in EW bits yields the signed biased exponent.
  assign w_exp_sum = EW'(w_ex) + EW'(w_ey) - C_BIAS + EW'(w_prod[PW-1]);

  // ---------------------------------------------------------------- round
  logic             w_inc, w_carry, w_ovf, w_unf;
  logic [MAN_W+1:0] w_mant_rnd;
  logic [MAN_W-1:0] w_frac;
  logic [EW-1:0]    w_exp_rnd;
  logic [W-1:0]     w_round_res;

  assign w_inc      = r_guard & (r_sticky | r_mant[0]);
  assign w_mant_rnd = {1'b0, r_mant} + {{(MAN_W+1){1'b0}}, w_inc};
  // Carry out only happens from an all-ones significand, leaving fraction 0.
  assign w_carry    = w_mant_rnd[MAN_W+1];
  assign w_frac     = w_carry ? w_mant_rnd[MAN_W:1] : w_mant_rnd[MAN_W-1:0];
  assign w_exp_rnd  = r_exp + {{(EW-1){1'b0}}, w_carry};
  assign w_ovf      = ~w_exp_rnd[EW-1] & (w_exp_rnd >= C_EXP_MAX);
  assign w_unf      = w_exp_rnd[EW-1] | (w_exp_rnd == '0);

  always_comb begin
    w_round_res = {w_sign, w_exp_rnd[EXP_W-1:0], w_frac};
    if (w_ovf) begin
      w_round_res = {w_sign, C_INF_MAG};
    end else if (w_unf) begin
      w_round_res = {w_sign, {(W-1){1'b0}}};
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (rd) w_next_state = S_SPECIAL;
      S_SPECIAL: w_next_state = w_special ? S_PUT_Z : S_MULT;
      S_MULT:    w_next_state = S_ROUND;
      S_ROUND:   w_next_state = S_PUT_Z;
      S_PUT_Z:   w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_mant   <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_exp    <= '0;
      r_res    <= '0;
      z        <= '0;
      wr       <= 1'b0;
    end else begin
      wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rd) begin
            r_x <= x;
            r_y <= y;
          end
        end
        S_SPECIAL: r_res <= w_spec_res;
        S_MULT: begin
          r_mant   <= w_norm[PW-1:MAN_W+1];
          r_guard  <= w_norm[MAN_W];
          r_sticky <= |w_norm[MAN_W-1:0];
          r_exp    <= w_exp_sum;
        end
        S_ROUND: r_res <= w_round_res;
        S_PUT_Z: begin
          z  <= r_res;
          wr <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- flags
`ifdef MULTIPLIER_FPN_FLAGS_EN
  logic       w_spec_inv;
  logic [3:0] r_res_flags;
  logic [3:0] r_flags;

  // Only a signalling NaN (fraction MSB clear) or inf x zero is invalid.
  assign w_spec_inv = w_any_nan ? ((w_x_nan & ~w_fx[MAN_W-1]) | (w_y_nan & ~w_fy[MAN_W-1]))
                                : w_inf_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_flags <= 4'b0;
      r_flags     <= 4'b0;
    end else begin
      case (r_state)
        S_SPECIAL: r_res_flags <= {w_spec_inv, 3'b000};
        S_ROUND:   r_res_flags <= {1'b0, w_ovf, w_unf & ~w_ovf,
                                   r_guard | r_sticky | w_ovf | w_unf};
        S_PUT_Z:   r_flags     <= r_res_flags;
        default:   ;
      endcase
    end
  end

  assign flags = r_flags;
`else
  assign flags = 4'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multiplier_fpn.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_multiplier_fpn                                          |
// | Description : Self-checking bench for multiplier_fpn (fp32 and fp16      |
// |               instances) with a value-level reference model.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multiplier_fpn;

`ifdef MULTIPLIER_FPN_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd32 = 1'b0;
  logic [31:0] x32 = '0, y32 = '0;
  logic [31:0] z32;
  logic        wr32, busy32;
  logic [3:0]  fl32;
  logic        rd16 = 1'b0;
  logic [15:0] x16 = '0, y16 = '0;
  logic [15:0] z16;
  logic        wr16, busy16;
  logic [3:0]  fl16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multiplier_fpn u_dut32 (
    .clk(clk), .reset(reset), .rd(rd32), .x(x32), .y(y32),
    .z(z32), .wr(wr32), .busy(busy32), .flags(fl32)
  );

  multiplier_fpn #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk(clk), .reset(reset), .rd(rd16), .x(x16), .y(y16),
    .z(z16), .wr(wr16), .busy(busy16), .flags(fl16)
  );

  // Reference: {special_path, flags, z}, from exact integer significand product.
  function automatic logic [36:0] fp_model(input int ew, input int mw,
                                           input logic [31:0] a, input logic [31:0] b);
    longint emax, bias, fmask, ea, eb, fa, fb, sgn, qnan, prod, q, rem, half, e, zz;
    int drop;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inv, spec;
    logic [3:0] fl;
    emax  = (longint'(1) << ew) - 1;
    bias  = (longint'(1) << (ew - 1)) - 1;
    fmask = (longint'(1) << mw) - 1;
    ea = (longint'(a) >> mw) & emax;  fa = longint'(a) & fmask;
    eb = (longint'(b) >> mw) & emax;  fb = longint'(b) & fmask;
    sgn = ((longint'(a) >> (ew + mw)) ^ (longint'(b) >> (ew + mw))) & 1;
    qnan = (emax << mw) | (longint'(1) << (mw - 1));
    a_nan = (ea == emax) && (fa != 0);  b_nan = (eb == emax) && (fb != 0);
    a_inf = (ea == emax) && (fa == 0);  b_inf = (eb == emax) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);    b_zero = (eb == 0) && (fb == 0);
    spec = 1'b1;
    fl = 4'b0;
    if (a_nan || b_nan) begin
      inv = (a_nan && ((fa >> (mw - 1)) & 1) == 0) || (b_nan && ((fb >> (mw - 1)) & 1) == 0);
      zz = qnan;  fl = {inv, 3'b000};
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      zz = qnan;  fl = 4'b1000;
    end else if (a_inf || b_inf) begin
      zz = (sgn << (ew + mw)) | (emax << mw);
    end else if (ea == 0 || eb == 0) begin
      zz = sgn << (ew + mw);
    end else begin
      spec = 1'b0;
      prod = (fa | (longint'(1) << mw)) * (fb | (longint'(1) << mw));
      e = ea + eb - bias;
      if (prod >= (longint'(1) << (2 * mw + 1))) begin drop = mw + 1; e = e + 1; end
      else drop = mw;
      q    = prod >> drop;
      rem  = prod & ((longint'(1) << drop) - 1);
      half = longint'(1) << (drop - 1);
      if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
      if (q == (longint'(1) << (mw + 1))) begin q = q >> 1; e = e + 1; end
      if (e >= emax) begin
        zz = (sgn << (ew + mw)) | (emax << mw);  fl = 4'b0101;
      end else if (e <= 0) begin
        zz = sgn << (ew + mw);  fl = 4'b0011;
      end else begin
        zz = (sgn << (ew + mw)) | (e << mw) | (q & fmask);
        fl = {3'b000, rem != 0};
      end
    end
    return {spec, fl, 32'(zz)};
  endfunction

  function automatic logic [31:0] rand_fp(input int ew, input int mw);
    int emax = (1 << ew) - 1;
    longint fmask = (longint'(1) << mw) - 1;
    longint e, f, s;
    int unsigned cat = $urandom_range(0, 15);
    f = longint'($urandom) & fmask;
    s = longint'($urandom_range(0, 1));
    case (cat)
      0:       begin e = 0;    if ($urandom_range(0, 1) == 0) f = 0; end
      1:       begin e = emax; if ($urandom_range(0, 1) == 0) f = 0; end
      2:       e = longint'($urandom_range(1, 3));
      3:       e = longint'(emax) - longint'($urandom_range(1, 3));
      default: e = longint'($urandom_range(1, emax - 1));
    endcase
    return 32'((s << (ew + mw)) | (e << mw) | f);
  endfunction

  function automatic logic [31:0] rand_norm32();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'(107 + $urandom_range(0, 40));
    return v;
  endfunction

  task automatic do_op32(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] zo, output logic [3:0] fo, output int lat);
    @(negedge clk);
    rd32 = 1'b1; x32 = a; y32 = b;
    @(posedge clk); #1;
    rd32 = 1'b0;
    lat = 0; zo = '0; fo = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (wr32 === 1'b1) begin lat = i; zo = z32; fo = fl32; break; end
    end
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] zo, output logic [3:0] fo, output int lat);
    @(negedge clk);
    rd16 = 1'b1; x16 = a; y16 = b;
    @(posedge clk); #1;
    rd16 = 1'b0;
    lat = 0; zo = '0; fo = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (wr16 === 1'b1) begin lat = i; zo = z16; fo = fl16; break; end
    end
  endtask

  task automatic test_reset();
    logic [45:0] obs;
    repeat (3) @(negedge clk);
    obs = {z32, wr32, busy32, fl32, wr16, busy16, fl16};
    n_checks++;
    if (obs !== 46'b0) $display("FAIL reset_low: got %h expected 0", obs);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    obs = {z32, wr32, busy32, fl32, wr16, busy16, fl16};
    n_checks++;
    if (obs !== 46'b0) $display("FAIL reset_release: got %h expected 0", obs);
    else n_pass++;
  endtask

  typedef struct packed {
    logic [31:0] a, b, z;
    logic [3:0]  f;
    logic [3:0]  lat;
  } dcase_t;

  task automatic test_directed();
    dcase_t cases [10] = '{
      '{32'h40400000, 32'hC0000000, 32'hC0C00000, 4'b0000, 4'd4},
      '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 4'd4},
      '{32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001, 4'd4},
      '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101, 4'd4},
      '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 4'd4},
      '{32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000, 4'd2},
      '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 4'd2},
      '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0000, 4'd2},
      '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 4'd2},
      '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 4'd2}
    };
    logic [31:0] zo; logic [3:0] fo; int lat;
    for (int i = 0; i < 10; i++) begin
      do_op32(cases[i].a, cases[i].b, zo, fo, lat);
      n_checks++;
      if (zo !== cases[i].z) $display("FAIL dir%0d_z: got %h expected %h", i, zo, cases[i].z);
      else n_pass++;
      n_checks++;
      if (fo !== (FLAGS_EN ? cases[i].f : 4'b0))
        $display("FAIL dir%0d_flags: got %b expected %b", i, fo, FLAGS_EN ? cases[i].f : 4'b0);
      else n_pass++;
      n_checks++;
      if (lat !== int'(cases[i].lat))
        $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, cases[i].lat);
      else n_pass++;
    end
  endtask

  task automatic test_busy();
    @(negedge clk); rd32 = 1'b1; x32 = 32'h40400000; y32 = 32'hC0000000;
    @(posedge clk); #1; rd32 = 1'b0;
    n_checks++;
    if (busy32 !== 1'b1) $display("FAIL busy_rise: got %b expected 1", busy32); else n_pass++;
    // A request while busy must be dropped, not queued.
    @(negedge clk); rd32 = 1'b1; x32 = 32'h3F800000; y32 = 32'h3F800000;
    @(posedge clk); #1; rd32 = 1'b0;
    n_checks++;
    if (wr32 !== 1'b0) $display("FAIL busy_wr_early: got %b expected 0", wr32); else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy32, wr32} !== 2'b10) $display("FAIL busy_k3: got %b expected 10", {busy32, wr32});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({busy32, wr32, z32} !== {2'b01, 32'hC0C00000})
      $display("FAIL busy_k4: got %h expected %h", {busy32, wr32, z32}, {2'b01, 32'hC0C00000});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({busy32, wr32, z32} !== {2'b00, 32'hC0C00000})
      $display("FAIL busy_k5_hold: got %h expected %h", {busy32, wr32, z32}, {2'b00, 32'hC0C00000});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int wr_count = 0;
    @(negedge clk); rd32 = 1'b1; x32 = 32'h3F800001; y32 = 32'h40000000;
    @(posedge clk); #1; rd32 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({z32, wr32, busy32, fl32} !== 38'b0)
      $display("FAIL reset_mid_outputs: got %h expected 0", {z32, wr32, busy32, fl32});
    else n_pass++;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wr32 === 1'b1) wr_count++;
    end
    n_checks++;
    if (wr_count !== 0) $display("FAIL reset_mid_no_wr: got %0d expected 0", wr_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] qa[$], qb[$];
    logic [36:0] m;
    logic exp_wr;
    for (int e = 0; e < 30; e++) begin
      @(negedge clk);
      rd32 = 1'b1; x32 = rand_norm32(); y32 = rand_norm32();
      qa.push_back(x32); qb.push_back(y32);
      @(posedge clk); #1;
      exp_wr = (e >= 4) && ((e - 4) % 5 == 0);
      n_checks++;
      if (wr32 !== exp_wr) $display("FAIL b2b_wr_e%0d: got %b expected %b", e, wr32, exp_wr);
      else n_pass++;
      if (exp_wr) begin
        m = fp_model(8, 23, qa[e-4], qb[e-4]);
        n_checks++;
        if (z32 !== m[31:0]) $display("FAIL b2b_z_e%0d: got %h expected %h", e, z32, m[31:0]);
        else n_pass++;
        n_checks++;
        if (fl32 !== (FLAGS_EN ? m[35:32] : 4'b0))
          $display("FAIL b2b_flags_e%0d: got %b expected %b", e, fl32, FLAGS_EN ? m[35:32] : 4'b0);
        else n_pass++;
      end
    end
    @(negedge clk); rd32 = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random32();
    logic [31:0] a, b, zo; logic [3:0] fo; int lat; logic [36:0] m;
    for (int i = 0; i < 300; i++) begin
      a = rand_fp(8, 23); b = rand_fp(8, 23);
      m = fp_model(8, 23, a, b);
      do_op32(a, b, zo, fo, lat);
      n_checks++;
      if (zo !== m[31:0]) $display("FAIL rnd32_z %h*%h: got %h expected %h", a, b, zo, m[31:0]);
      else n_pass++;
      n_checks++;
      if (fo !== (FLAGS_EN ? m[35:32] : 4'b0))
        $display("FAIL rnd32_flags %h*%h: got %b expected %b", a, b, fo, FLAGS_EN ? m[35:32] : 4'b0);
      else n_pass++;
      n_checks++;
      if (lat !== (m[36] ? 2 : 4)) $display("FAIL rnd32_latency %h*%h: got %0d expected %0d", a, b, lat, m[36] ? 2 : 4);
      else n_pass++;
    end
  endtask

  task automatic test_fp16();
    logic [15:0] a, b, zo; logic [3:0] fo; int lat; logic [36:0] m;
    do_op16(16'h4200, 16'h4000, zo, fo, lat);
    n_checks++;
    if ({zo, fo, lat[3:0]} !== {16'h4600, 4'b0000, 4'd4})
      $display("FAIL fp16_basic: got %h expected %h", {zo, fo, lat[3:0]}, {16'h4600, 4'b0000, 4'd4});
    else n_pass++;
    for (int i = 0; i < 150; i++) begin
      a = 16'(rand_fp(5, 10)); b = 16'(rand_fp(5, 10));
      m = fp_model(5, 10, {16'b0, a}, {16'b0, b});
      do_op16(a, b, zo, fo, lat);
      n_checks++;
      if (zo !== m[15:0]) $display("FAIL rnd16_z %h*%h: got %h expected %h", a, b, zo, m[15:0]);
      else n_pass++;
      n_checks++;
      if (fo !== (FLAGS_EN ? m[35:32] : 4'b0))
        $display("FAIL rnd16_flags %h*%h: got %b expected %b", a, b, fo, FLAGS_EN ? m[35:32] : 4'b0);
      else n_pass++;
      n_checks++;
      if (lat !== (m[36] ? 2 : 4)) $display("FAIL rnd16_latency %h*%h: got %0d expected %0d", a, b, lat, m[36] ? 2 : 4);
      else n_pass++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_random32();
    test_fp16();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
